// File: rtl/turbo_codec_pkg.sv
// Shared definitions for the turbo codec blocks: decoder FSM encoding,
// default sizes and the RSC constituent-code trellis.
package turbo_codec_pkg;

  localparam int DEF_BLK_LEN = 8;
  localparam int DEF_PM_W    = 5;
  localparam int DEF_PM_MAX  = (1 << DEF_PM_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACS,
    ST_SEL,
    ST_TB,
    ST_OUT
  } dec_state_e;

  // State index bit0 = s0 (newest). Returns {parity, next_state}.
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic u);
    logic a;
    logic p;
    a = u ^ s[1] ^ s[2];
    p = a ^ s[0] ^ s[2];
    return {p, s[1], s[0], a};
  endfunction

  function automatic int pm_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/rsc_acs_unit.sv
// Combinational add-compare-select over all 8 trellis states for one
// received hard-decision symbol.
module rsc_acs_unit
  import turbo_codec_pkg::*;
#(
  parameter int PM_W = DEF_PM_W
) (
  input  logic [8*PM_W-1:0] pm_in,
  input  logic              sym_sys,
  input  logic              sym_par,
  output logic [8*PM_W-1:0] pm_out,
  output logic [7:0]        dec
);

  logic [PM_W-1:0] cand [8][2];
  logic [3:0]      tr;
  logic [1:0]      bm;
  logic [PM_W:0]   sum;
  logic            ub;

  // Each next state is reached from exactly two predecessors differing in
  // s2, so cand[ns][s2] collects both branches before the compare.
  always_comb begin
    cand   = '{default: '0};
    pm_out = '0;
    dec    = '0;
    tr     = '0;
    bm     = '0;
    sum    = '0;
    ub     = 1'b0;
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        ub  = (u != 0);
        tr  = rsc_step(3'(s), ub);
        bm  = {1'b0, ub ^ sym_sys} + {1'b0, tr[3] ^ sym_par};
        sum = {1'b0, pm_in[s*PM_W +: PM_W]} + (PM_W+1)'(bm);
        cand[tr[2:0]][s/4] = sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
      end
    end
    for (int ns = 0; ns < 8; ns++) begin
      if (cand[ns][1] < cand[ns][0]) begin
        pm_out[ns*PM_W +: PM_W] = cand[ns][1];
        dec[ns]                 = 1'b1;
      end else begin
        pm_out[ns*PM_W +: PM_W] = cand[ns][0];
      end
    end
  end

endmodule

// File: rtl/rsc_viterbi_decoder.sv
// Block hard-decision Viterbi decoder for the 8-state RSC constituent code:
// ACS per symbol, best end-state select, traceback, then in-order output.
module rsc_viterbi_decoder
  import turbo_codec_pkg::*;
#(
  parameter int BLK_LEN = DEF_BLK_LEN,
  parameter int PM_W    = DEF_PM_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sym_valid,
  input  logic            sym_first,
  input  logic            sym_sys,
  input  logic            sym_par,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_bit,
  output logic            out_last,
  output logic [PM_W-1:0] out_metric
);

  localparam int                STEP_W    = $clog2(BLK_LEN);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BLK_LEN - 1);
  localparam logic [PM_W-1:0]   PM_MAX    = PM_W'(pm_max(PM_W));
  localparam logic [8*PM_W-1:0] PM_INIT   = {{7{PM_MAX}}, {PM_W{1'b0}}};

  dec_state_e          state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PM_W-1:0]     out_metric_q, out_metric_d;
  logic [8*PM_W-1:0]   pm_q, pm_d;
  logic [7:0]          dec_mem_q [BLK_LEN];
  logic [7:0]          dec_mem_d [BLK_LEN];
  logic [BLK_LEN-1:0]  bits_q, bits_d;
  logic [2:0]          tb_state_q, tb_state_d;

  logic [8*PM_W-1:0]   acs_pm_in, acs_pm_out;
  logic [7:0]          acs_dec;
  logic                accept;
  logic                tb_dec;
  logic [2:0]          best_idx;
  logic [PM_W-1:0]     best_pm;

  assign accept     = sym_valid && (state_q == ST_IDLE || state_q == ST_ACS);
  assign acs_pm_in  = (state_q == ST_IDLE || sym_first) ? PM_INIT : pm_q;
  assign tb_dec     = dec_mem_q[step_q][tb_state_q];
  assign out_metric = out_metric_q;

  rsc_acs_unit #(.PM_W(PM_W)) u_acs (
    .pm_in   (acs_pm_in),
    .sym_sys (sym_sys),
    .sym_par (sym_par),
    .pm_out  (acs_pm_out),
    .dec     (acs_dec)
  );

  // Strict compare keeps the lowest-index end state on ties.
  always_comb begin
    best_idx = '0;
    best_pm  = pm_q[PM_W-1:0];
    for (int i = 1; i < 8; i++) begin
      if (pm_q[i*PM_W +: PM_W] < best_pm) begin
        best_pm  = pm_q[i*PM_W +: PM_W];
        best_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    out_metric_d = out_metric_q;
    pm_d         = pm_q;
    dec_mem_d    = dec_mem_q;
    bits_d       = bits_q;
    tb_state_d   = tb_state_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_bit      = 1'b0;
    out_last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept && sym_first) begin
          pm_d         = acs_pm_out;
          dec_mem_d[0] = acs_dec;
          step_d       = STEP_W'(1);
          state_d      = ST_ACS;
        end
      end
      ST_ACS: begin
        in_ready = 1'b1;
        if (accept) begin
          pm_d = acs_pm_out;
          if (sym_first) begin
            dec_mem_d[0] = acs_dec;
            step_d       = STEP_W'(1);
          end else begin
            dec_mem_d[step_q] = acs_dec;
            if (step_q == LAST_STEP) begin
              state_d = ST_SEL;
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
      end
      ST_SEL: begin
        tb_state_d   = best_idx;
        out_metric_d = best_pm;
        step_d       = LAST_STEP;
        state_d      = ST_TB;
      end
      ST_TB: begin
        bits_d[step_q] = tb_state_q[0] ^ tb_state_q[2] ^ tb_dec;
        tb_state_d     = {tb_dec, tb_state_q[2], tb_state_q[1]};
        if (step_q == '0) begin
          state_d = ST_OUT;
        end else begin
          step_d = step_q - STEP_W'(1);
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_bit   = bits_q[step_q];
        out_last  = (step_q == LAST_STEP);
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = ST_IDLE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      out_metric_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      out_metric_q <= out_metric_d;
    end
  end

  always_ff @(posedge clk) begin
    pm_q       <= pm_d;
    dec_mem_q  <= dec_mem_d;
    bits_q     <= bits_d;
    tb_state_q <= tb_state_d;
  end

endmodule

// File: tb/tb_rsc_viterbi_decoder.sv
// Self-checking bench for rsc_viterbi_decoder: vector table of blocks plus
// restart, ignored-symbol and reset-abort sequences, scored through a queue.
module tb_rsc_viterbi_decoder;
  import turbo_codec_pkg::*;

  localparam int BLK_LEN = 8;
  localparam int PM_W    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            sym_valid;
  logic            sym_first;
  logic            sym_sys;
  logic            sym_par;
  logic            in_ready;
  logic            out_valid;
  logic            out_bit;
  logic            out_last;
  logic [PM_W-1:0] out_metric;

  typedef struct {
    logic            bit_v;
    logic            last;
    logic [PM_W-1:0] metric;
  } exp_t;

  typedef struct {
    logic [BLK_LEN-1:0] sys;
    logic [BLK_LEN-1:0] par;
    int                 gap;
    logic [BLK_LEN-1:0] exp_bits;
    int                 exp_metric;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  int total    = 0;
  int passed   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int out_cnt  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsc_viterbi_decoder #(.BLK_LEN(BLK_LEN), .PM_W(PM_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym_first  (sym_first),
    .sym_sys    (sym_sys),
    .sym_par    (sym_par),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_last   (out_last),
    .out_metric (out_metric)
  );

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference encoder: parity stream of the RSC code from the zero state.
  function automatic logic [BLK_LEN-1:0] encode(input logic [BLK_LEN-1:0] u);
    logic s0, s1, s2, a;
    logic [BLK_LEN-1:0] p;
    s0 = 0; s1 = 0; s2 = 0; p = '0;
    for (int i = 0; i < BLK_LEN; i++) begin
      a    = u[i] ^ s1 ^ s2;
      p[i] = a ^ s0 ^ s2;
      s2 = s1; s1 = s0; s0 = a;
    end
    return p;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_output("spurious_out_valid", int'(out_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output($sformatf("out_bit[%0d]", out_cnt), int'(out_bit), int'(e.bit_v));
        check_output($sformatf("out_last[%0d]", out_cnt), int'(out_last), int'(e.last));
        check_output($sformatf("out_metric[%0d]", out_cnt), int'(out_metric), int'(e.metric));
        if (out_cnt == 0) check_output("first_out_latency", cyc - last_acc, BLK_LEN + 2);
      end
      out_cnt++;
      if (out_last) begin
        out_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic push_expected(input logic [BLK_LEN-1:0] bits, input int metric);
    for (int i = 0; i < BLK_LEN; i++)
      sb.push_back('{bits[i], (i == BLK_LEN - 1), PM_W'(metric)});
  endtask

  task automatic apply_stimulus(input vec_t v, input int nsym);
    for (int i = 0; i < nsym; i++) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_first = (i == 0);
      sym_sys   = v.sys[i];
      sym_par   = v.par[i];
      check_output($sformatf("in_ready_sym%0d", i), int'(in_ready), 1);
      last_acc  = cyc;
      if (i < nsym - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk);
          sym_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    sym_valid = 1'b0;
    sym_first = 1'b0;
  endtask

  task automatic wait_block(input string name);
    int start;
    start = done_cnt;
    for (int k = 0; k < 4 * BLK_LEN + 60; k++) begin
      @(posedge clk);
      if (done_cnt != start) break;
    end
    check_output({name, "_done"}, done_cnt - start, 1);
    @(negedge clk);
    check_output({name, "_idle_ready"}, int'(in_ready), 1);
    check_output({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

  initial begin
    logic [BLK_LEN-1:0] u;
    int ov_cnt;
    reset = 1'b1; sym_valid = 1'b0; sym_first = 1'b0; sym_sys = 1'b0; sym_par = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", int'(in_ready), 1);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_bit", int'(out_bit), 0);
    check_output("rst_out_last", int'(out_last), 0);
    check_output("rst_out_metric", int'(out_metric), 0);
    reset = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 0, 8'h00, 0};
    vecs[1] = '{8'h01, 8'b0100_1111, 0, 8'h01, 0};
    vecs[2] = '{8'h01, 8'b0100_1101, 0, 8'h01, 1};
    vecs[3] = '{8'h01, 8'b0100_1111, 3, 8'h01, 0};
    for (int i = 4; i < 7; i++) begin
      u = BLK_LEN'($urandom);
      vecs[i] = '{u, encode(u), int'($urandom_range(0, 2)), u, 0};
    end

    for (int i = 0; i < 7; i++) begin
      push_expected(vecs[i].exp_bits, vecs[i].exp_metric);
      apply_stimulus(vecs[i], BLK_LEN);
      wait_block($sformatf("vec%0d", i));
    end

    // Stray non-first symbols, aborted partial block, then a full zero block.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sym_valid = 1'b1; sym_first = 1'b0; sym_sys = 1'b1; sym_par = 1'b1;
    end
    apply_stimulus(vecs[1], 5);
    push_expected(8'h00, 0);
    apply_stimulus(vecs[0], BLK_LEN);
    for (int k = 0; k < 4 * BLK_LEN; k++) begin
      @(negedge clk);
      if (out_valid && out_last) begin
        sym_valid = 1'b0;
        sym_first = 1'b0;
        break;
      end
      check_output("busy_in_ready", int'(in_ready), 0);
      sym_valid = 1'b1;
      sym_first = 1'b1;
      sym_sys   = 1'($urandom);
      sym_par   = 1'($urandom);
    end
    @(negedge clk);
    check_output("restart_idle_ready", int'(in_ready), 1);
    check_output("restart_sb_empty", sb.size(), 0);

    // Reset mid-traceback aborts the block without output.
    apply_stimulus(vecs[2], BLK_LEN);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("tb_reset_in_ready", int'(in_ready), 1);
    check_output("tb_reset_out_valid", int'(out_valid), 0);
    check_output("tb_reset_out_metric", int'(out_metric), 0);
    ov_cnt = 0;
    for (int k = 0; k < 2 * BLK_LEN + 10; k++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check_output("tb_reset_no_output", ov_cnt, 0);
    push_expected(vecs[1].exp_bits, vecs[1].exp_metric);
    apply_stimulus(vecs[1], BLK_LEN);
    wait_block("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
